// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master: FSM state encoding, frame geometry
// and the smallest supported SCLK half-period divider.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } spi_state_e;

    localparam int FRAME_BITS  = 16;
    localparam int ADDR_BITS   = 8;
    localparam int DATA_BITS   = FRAME_BITS - ADDR_BITS;
    localparam int CLK_DIV_MIN = 4;

endpackage

// File: rtl/spi_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
// Half-period counter for the SPI master. Reloaded on every FSM state entry;
// asserts o_tick in the last cycle of a CLK_DIV-cycle phase so the FSM moves
// on at the following edge.
//
// Ports:
//   i_clk   system clock (rising edge)
//   i_rst   synchronous active-high reset
//   i_load  reload the counter (asserted in the cycle before a new state)
//   i_run   qualifies the tick; low while the FSM is idle
//   o_tick  phase-complete strobe
// -----------------------------------------------------------------------------
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_tick = i_run && (r_cnt == 8'd0);

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Host-side SPI (mode 0) master. Sends one 16-bit frame per request, address
// byte in bits 15:8 and data byte in bits 7:0, MSB first, with every SCLK
// half-period lasting CLK_DIV system clocks so a slave that oversamples SCLK
// can sample each bit reliably.
//
// Build option: define SPI_MASTER_READBACK_EN to implement MISO capture into
// o_rx_data. When undefined, MISO is ignored and o_rx_data is constant 0.
//
// Ports:
//   i_clk          system clock (rising edge)
//   i_rst          synchronous active-high reset; aborts any frame
//   i_start        frame request, honoured only while idle
//   i_tx_address   address byte (frame bits 15:8)
//   i_tx_data      data byte (frame bits 7:0)
//   i_miso         serial data from the slave
//   o_sclk         SPI clock, idles low
//   o_mosi         serial data to the slave
//   o_ss           slave select, active low
//   o_busy         high from request acceptance through the inter-frame gap
//   o_done         one-cycle pulse in the cycle o_ss returns high
//   o_rx_data      last frame captured from MISO
// -----------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_BITS-1:0]  i_tx_address,
    input  logic [DATA_BITS-1:0]  i_tx_data,
    input  logic                  i_miso,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic                  o_ss,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [FRAME_BITS-1:0] o_rx_data
);

    // Dividers below the minimum cannot be sampled by the slave; clamp them.
    localparam int DIV = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;

    spi_state_e            r_state;
    spi_state_e            w_next_state;
    logic [FRAME_BITS-1:0] r_tx_sr;
    logic [FRAME_BITS-1:0] w_tx_sr_next;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            w_bit_cnt_next;
    logic                  w_tick;
    logic                  w_state_change;
    logic                  w_accept;
    logic                  w_lo_entry;
    logic                  w_hi_entry;
    logic                  w_gap_entry;
    logic                  w_frame_active_next;

    logic r_sclk;
    logic r_mosi;
    logic r_ss;
    logic r_busy;
    logic r_done;

    spi_tick_gen #(
        .CLK_DIV (DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_state_change),
        .i_run  (r_state != IDLE),
        .o_tick (w_tick)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (i_start) w_next_state = SETUP;
            SETUP:    if (w_tick)  w_next_state = SHIFT_HI;
            SHIFT_HI: if (w_tick)  w_next_state = SHIFT_LO;
            // The bit counter wraps to 15 on entry to the 16th (hold) low
            // phase, which is how the end of the frame is recognised.
            SHIFT_LO: if (w_tick)  w_next_state = (r_bit_cnt == 4'd15) ? GAP : SHIFT_HI;
            GAP:      if (w_tick)  w_next_state = IDLE;
            default:               w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_state_change      = (w_next_state != r_state);
        w_accept            = (r_state == IDLE) && i_start;
        w_lo_entry          = (w_next_state == SHIFT_LO) && (r_state != SHIFT_LO);
        w_hi_entry          = (w_next_state == SHIFT_HI) && (r_state != SHIFT_HI);
        w_gap_entry         = (w_next_state == GAP) && (r_state != GAP);
        w_frame_active_next = (w_next_state == SETUP) || (w_next_state == SHIFT_HI) ||
                              (w_next_state == SHIFT_LO);

        w_tx_sr_next   = r_tx_sr;
        w_bit_cnt_next = r_bit_cnt;
        if (w_accept) begin
            w_tx_sr_next   = {i_tx_address, i_tx_data};
            w_bit_cnt_next = 4'd15;
        end else if (w_lo_entry) begin
            w_bit_cnt_next = r_bit_cnt - 4'd1;
            // On the last low phase bit 0 stays on MOSI as the hold bit.
            if (r_bit_cnt != 4'd0) begin
                w_tx_sr_next = r_tx_sr << 1;
            end
        end
    end

    // Pin outputs are registered from the next-state values so they change
    // together with the state and never glitch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_tx_sr   <= '0;
            r_bit_cnt <= 4'd15;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_ss      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_tx_sr   <= w_tx_sr_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_sclk    <= (w_next_state == SHIFT_HI);
            r_mosi    <= w_frame_active_next ? w_tx_sr_next[FRAME_BITS-1] : 1'b0;
            r_ss      <= !w_frame_active_next;
            r_busy    <= (w_next_state != IDLE);
            r_done    <= w_gap_entry;
        end
    end

    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_ss   = r_ss;
    assign o_busy = r_busy;
    assign o_done = r_done;

`ifdef SPI_MASTER_READBACK_EN
    logic [FRAME_BITS-1:0] r_rx_sr;
    logic [FRAME_BITS-1:0] r_rx_data;

    // The shift register needs no per-frame clear: all 16 bits are replaced
    // by the 16 rising edges of every frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_sr   <= '0;
            r_rx_data <= '0;
        end else begin
            if (w_hi_entry) begin
                r_rx_sr <= {r_rx_sr[FRAME_BITS-2:0], i_miso};
            end
            if (w_gap_entry) begin
                r_rx_data <= r_rx_sr;
            end
        end
    end

    assign o_rx_data = r_rx_data;
`else
    logic w_unused_rx;
    assign w_unused_rx = i_miso ^ w_hi_entry;
    assign o_rx_data   = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Self-checking bench for spi_master with CLK_DIV=4. Each scenario records the
// DUT pins cycle by cycle (cycle 0 = the cycle START is presented in IDLE) and
// then compares the trace against expectations derived from the frame timing
// rules: SS low for cycles s+1..s+33*DIV, DONE at s+1+33*DIV, BUSY through
// s+34*DIV, MOSI carrying the frame MSB first on the SCLK rising edges.
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int DIV  = 4;
    localparam int NMAX = 300;
`ifdef SPI_MASTER_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  tx_addr;
    logic [7:0]  tx_data;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic        ss;
    logic        busy;
    logic        done;
    logic [15:0] rx_data;
    int          miso_mode;   // 0: loopback, 1: inverted loopback, 2: tied high

    int total = 0;
    int bad   = 0;

    logic        h_ss   [NMAX];
    logic        h_sclk [NMAX];
    logic        h_mosi [NMAX];
    logic        h_busy [NMAX];
    logic        h_done [NMAX];
    logic [15:0] h_rx   [NMAX];

    always #5 clk = ~clk;

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? ~mosi : 1'b1;

    spi_master #(
        .CLK_DIV (DIV)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_tx_address (tx_addr),
        .i_tx_data    (tx_data),
        .i_miso       (miso),
        .o_sclk       (sclk),
        .o_mosi       (mosi),
        .o_ss         (ss),
        .o_busy       (busy),
        .o_done       (done),
        .o_rx_data    (rx_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int c);
        h_ss[c]   = ss;
        h_sclk[c] = sclk;
        h_mosi[c] = mosi;
        h_busy[c] = busy;
        h_done[c] = done;
        h_rx[c]   = rx_data;
    endtask

    // START is presented in cycle 0; then n cycles are recorded. Optional
    // events (-1 disables): change TX_DATA, extra START pulse, one-cycle reset.
    task automatic run(input int n, input bit hold, input int chg_cyc, input logic [7:0] chg_val,
                       input int pulse_cyc, input int rst_cyc);
        @(negedge clk);
        sample(0);
        start = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            sample(c);
            start = (hold && c < n) || (c == pulse_cyc);
            if (c == chg_cyc) tx_data = chg_val;
            rst = (c == rst_cyc);
        end
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
        end
    endtask

    function automatic logic [15:0] exp_rx(input logic [15:0] f, input int mode);
        case (mode)
            0:       return f;
            1:       return ~f;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic int count_rises(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (h_sclk[c] && !h_sclk[c-1]) n++;
        return n;
    endfunction

    function automatic logic [15:0] mosi_word(input int lo, input int hi);
        logic [15:0] w = '0;
        int n = 0;
        for (int c = lo; c <= hi; c++) begin
            if (h_sclk[c] && !h_sclk[c-1] && n < 16) begin
                w = {w[14:0], h_mosi[c]};
                n++;
            end
        end
        return w;
    endfunction

    // MOSI must hold its value DIV cycles either side of every rising edge.
    function automatic int stab_viol(input int lo, input int hi);
        int v = 0;
        for (int c = lo; c <= hi; c++) begin
            if (h_sclk[c] && !h_sclk[c-1]) begin
                for (int k = c - DIV; k < c + DIV; k++) if (h_mosi[k] !== h_mosi[c]) v++;
            end
        end
        return v;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (h_done[c]) n++;
        return n;
    endfunction

    function automatic int first_done(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (h_done[c]) return c;
        return -1;
    endfunction

    function automatic int first_ss_low(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (!h_ss[c]) return c;
        return -1;
    endfunction

    function automatic int last_of_low_run(input int from, input int hi);
        int c = from;
        while (c < hi && !h_ss[c+1]) c++;
        return c;
    endfunction

    function automatic int first_busy_low(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (!h_busy[c]) return c;
        return -1;
    endfunction

    function automatic int count_ss_low(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (!h_ss[c]) n++;
        return n;
    endfunction

    // Checks one frame whose START was sampled at trace cycle s.
    task automatic check_frame(input string p, input int s, input logic [15:0] f, input int mode);
        int last = s + 33 * DIV;
        int sl;
        check({p, ".mosi_word"}, 32'(mosi_word(s + 1, last)), 32'(f));
        check({p, ".rises"},     32'(count_rises(s + 1, last)), 32'd16);
        check({p, ".mosi_stab"}, 32'(stab_viol(s + 1, last)), 32'd0);
        check({p, ".hold_mosi"}, 32'(h_mosi[last]), 32'(f[0]));
        sl = first_ss_low(s + 1, last);
        check({p, ".ss_fall"},   32'(sl), 32'(s + 1));
        check({p, ".ss_rise"},   32'(last_of_low_run(sl, last + 1) + 1), 32'(last + 1));
        check({p, ".done_n"},    32'(count_done(s + 1, s + 34 * DIV)), 32'd1);
        check({p, ".done_cyc"},  32'(first_done(s + 1, s + 34 * DIV)), 32'(last + 1));
        check({p, ".busy_on"},   32'(h_busy[s + 1]), 32'd1);
        check({p, ".busy_off"},  32'(first_busy_low(s + 1, s + 34 * DIV + 1)), 32'(s + 34 * DIV + 1));
        check({p, ".gap_pins"},  32'({h_mosi[last + 1], h_sclk[last + 1]}), 32'd0);
        check({p, ".rx"},        32'(h_rx[last + 1]), READBACK ? 32'(exp_rx(f, mode)) : 32'd0);
    endtask

    initial begin
        logic [15:0] frame;

        rst       = 1'b1;
        start     = 1'b0;
        tx_addr   = 8'h00;
        tx_data   = 8'h00;
        miso_mode = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst.sclk", 32'(sclk), 32'd0);
        check("rst.mosi", 32'(mosi), 32'd0);
        check("rst.ss",   32'(ss),   32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.rx",   32'(rx_data), 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // Basic frame with MISO looped back to MOSI
        tx_addr = 8'hA5; tx_data = 8'h3C; miso_mode = 0;
        run(140, 1'b0, -1, 8'h00, -1, -1);
        check("basic.rx_before", 32'(h_rx[132]), 32'd0);
        check_frame("basic", 0, 16'hA53C, 0);
        idle_cycles(3);

        // MISO tied high for the whole frame
        miso_mode = 2;
        run(140, 1'b0, -1, 8'h00, -1, -1);
        check_frame("miso_hi", 0, 16'hA53C, 2);
        idle_cycles(3);

        // START while busy, TX_DATA changed mid-frame
        miso_mode = 0;
        run(200, 1'b0, 10, 8'hFF, 50, -1);
        check_frame("busy_start", 0, 16'hA53C, 0);
        check("busy_start.done_total", 32'(count_done(1, 200)), 32'd1);
        check("busy_start.no_frame2",  32'(count_ss_low(137, 200)), 32'd0);
        idle_cycles(3);

        // Back-to-back with START held high
        tx_addr = 8'hA5; tx_data = 8'h3C;
        run(274, 1'b1, -1, 8'h00, -1, -1);
        check_frame("b2b_f1", 0, 16'hA53C, 0);
        check("b2b.gap_len",  32'(count_ss_low(133, 137)), 32'd0);
        check("b2b.ss_fall2", 32'(h_ss[138]), 32'd0);
        check_frame("b2b_f2", 137, 16'hA53C, 0);
        check("b2b.done_total", 32'(count_done(1, 274)), 32'd2);
        idle_cycles(3);

        // Random frames against the model
        for (int i = 0; i < 4; i++) begin
            tx_addr   = 8'($urandom);
            tx_data   = 8'($urandom);
            miso_mode = int'($urandom_range(0, 1));
            frame     = {tx_addr, tx_data};
            run(140, 1'b0, -1, 8'h00, -1, -1);
            check_frame($sformatf("rand%0d", i), 0, frame, miso_mode);
            idle_cycles(3);
        end

        // Reset mid-frame, then a clean frame starting at cycle 65
        tx_addr = 8'h5A; tx_data = 8'hC3; miso_mode = 0;
        run(64, 1'b0, -1, 8'h00, -1, 60);
        check("abort.ss",   32'(h_ss[61]),   32'd1);
        check("abort.sclk", 32'(h_sclk[61]), 32'd0);
        check("abort.mosi", 32'(h_mosi[61]), 32'd0);
        check("abort.busy", 32'(h_busy[61]), 32'd0);
        check("abort.rx",   32'(h_rx[61]),   32'd0);
        check("abort.no_done", 32'(count_done(1, 64)), 32'd0);
        tx_addr = 8'hA5; tx_data = 8'h3C;
        run(140, 1'b0, -1, 8'h00, -1, -1);
        check_frame("after_abort", 0, 16'hA53C, 0);
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
